// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: digit count,
// active-low glyph patterns (seg[6:0] = g,f,e,d,c,b,a) and the anode-off word.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int IDX_W      = 3;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [7:0] AN_OFF   = 8'hFF;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bundle between the BCD converter, the scanner and the board display pins.
// master = the side supplying digits, slave = the scanner driving the display.
interface seven_seg_scanner_if;

  logic       done;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic [3:0] bcd4;
  logic       blank_lz;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output done, bcd0, bcd1, bcd2, bcd3, bcd4, blank_lz,
    input  an, seg, dp
  );

  modport slave (
    input  done, bcd0, bcd1, bcd2, bcd3, bcd4, blank_lz,
    output an, seg, dp
  );

endinterface

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15
// render as a dash so corrupt digits are visible rather than misleading.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Captures five BCD digits on done and scans them across a common-anode
// display with a per-slot ghosting blank and optional leading-zero blanking.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  seven_seg_scanner_if.slave  bus
);

  localparam int               CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [3:0]       r_dig [NUM_DIGITS];
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_an_p1;
  logic [6:0]       r_seg_p1;

  logic [NUM_DIGITS-1:0] w_nz_tail;
  logic [3:0]            w_dig;
  logic                  w_tail_nz;
  logic                  w_blank;
  logic [6:0]            w_glyph;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= 4'd0;
    end else if (bus.done) begin
      r_dig[0] <= bus.bcd0;
      r_dig[1] <= bus.bcd1;
      r_dig[2] <= bus.bcd2;
      r_dig[3] <= bus.bcd3;
      r_dig[4] <= bus.bcd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // w_nz_tail[i] is set when any digit from i up to the top one is non-zero
  always_comb begin
    logic nz;
    nz        = 1'b0;
    w_nz_tail = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz           = nz | (r_dig[i] != 4'd0);
      w_nz_tail[i] = nz;
    end
  end

  always_comb begin
    w_dig     = r_dig[0];
    w_tail_nz = w_nz_tail[0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_dig     = r_dig[i];
        w_tail_nz = w_nz_tail[i];
      end
    end
    w_blank = (r_cnt < BLANK_END)
            | (bus.blank_lz & (r_idx != '0) & ~w_tail_nz);
  end

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_dig),
    .o_seg (w_glyph)
  );

  // ---- stage p1: registered display drive ----
  always_ff @(posedge clk) begin
    if (reset || w_blank) begin
      r_an_p1  <= AN_OFF;
      r_seg_p1 <= SEG_OFF;
    end else begin
      r_an_p1  <= ~(8'd1 << r_idx);
      r_seg_p1 <= w_glyph;
    end
  end

  assign bus.an  = r_an_p1;
  assign bus.seg = r_seg_p1;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scan scenarios followed by random
// traffic, every cycle compared against an arithmetic model of the display.
module tb_seven_seg_scanner;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 5 * RDIV;

  logic clk;
  logic reset;
  seven_seg_scanner_if bus ();

  seven_seg_scanner #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;
  int m_phase = 0;
  int m_d [5];

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic check_out(input string tag, input logic [7:0] ea, input logic [6:0] es);
    n_asrt++;
    assert (bus.an === ea) else begin
      n_fail++;
      $error("FAIL %s an: observed %h expected %h (t=%0t)", tag, bus.an, ea, $time);
    end
    n_asrt++;
    assert (bus.seg === es) else begin
      n_fail++;
      $error("FAIL %s seg: observed %h expected %h (t=%0t)", tag, bus.seg, es, $time);
    end
  endtask

  // One clock: predict from the pre-edge model state, clock, update model, compare.
  task automatic step();
    logic [7:0] ea;
    logic [6:0] es;
    int cnt, idx, tail;
    logic was_rst, was_done;
    int nb [5];
    was_rst  = reset;
    was_done = bus.done;
    nb[0] = bus.bcd0; nb[1] = bus.bcd1; nb[2] = bus.bcd2;
    nb[3] = bus.bcd3; nb[4] = bus.bcd4;
    ea = 8'hFF;
    es = 7'h7F;
    if (!was_rst) begin
      cnt  = m_phase % RDIV;
      idx  = m_phase / RDIV;
      tail = 0;
      for (int j = idx; j < 5; j++) tail += m_d[j];
      if (!(cnt < BLANK) && !(bus.blank_lz && idx >= 1 && tail == 0)) begin
        ea = 8'hFF ^ (8'd1 << idx);
        es = glyph(m_d[idx]);
      end
    end
    @(posedge clk);
    if (was_rst) begin
      m_phase = 0;
      for (int j = 0; j < 5; j++) m_d[j] = 0;
    end else begin
      if (was_done) for (int j = 0; j < 5; j++) m_d[j] = nb[j];
      m_phase = (m_phase + 1) % FRAME;
    end
    #1;
    check_out("scan", ea, es);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int d4, input int d3, input int d2, input int d1, input int d0);
    bus.done = 1'b1;
    bus.bcd4 = 4'(d4); bus.bcd3 = 4'(d3); bus.bcd2 = 4'(d2);
    bus.bcd1 = 4'(d1); bus.bcd0 = 4'(d0);
    step();
    bus.done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.done = 1'b0;
    bus.bcd0 = 4'd0; bus.bcd1 = 4'd0; bus.bcd2 = 4'd0;
    bus.bcd3 = 4'd0; bus.bcd4 = 4'd0;
    bus.blank_lz = 1'b1;

    // Reset held 3 cycles
    run(3);
    n_asrt++;
    assert (bus.dp === 1'b1) else begin
      n_fail++;
      $error("FAIL reset dp: observed %b expected 1", bus.dp);
    end
    check_out("reset_hold", 8'hFF, 7'h7F);
    reset = 1'b0;
    run(2);
    check_out("pre_lit", 8'hFF, 7'h7F);
    step();
    check_out("first_lit", 8'hFE, 7'h40);
    run(FRAME);

    // 754 with and without leading-zero blanking
    load(0, 0, 7, 5, 4);
    run(2 * FRAME);
    bus.blank_lz = 1'b0;
    run(2 * FRAME);

    // All zeros, then 10000
    bus.blank_lz = 1'b1;
    load(0, 0, 0, 0, 0);
    run(FRAME);
    load(1, 0, 0, 0, 0);
    run(FRAME);

    // Inputs move without done: display must hold
    bus.bcd0 = 4'd9; bus.bcd1 = 4'd8; bus.bcd2 = 4'd3; bus.bcd3 = 4'd6; bus.bcd4 = 4'd2;
    run(2 * FRAME);

    // Dash in digit 1 keeps it lit under blanking
    load(0, 0, 0, 12, 3);
    run(2 * FRAME);

    // Reset together with done in the middle of slot 2
    load(0, 3, 2, 1, 8);
    while (m_phase != 2 * RDIV + 4) step();
    reset = 1'b1;
    bus.done = 1'b1;
    bus.bcd0 = 4'd7; bus.bcd1 = 4'd7; bus.bcd2 = 4'd7; bus.bcd3 = 4'd7; bus.bcd4 = 4'd7;
    step();
    check_out("rst_done", 8'hFF, 7'h7F);
    reset = 1'b0;
    bus.done = 1'b0;
    bus.blank_lz = 1'b0;
    run(2 * FRAME);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      bus.done = ($urandom_range(0, 15) == 0);
      bus.bcd0 = 4'($urandom_range(0, 15));
      bus.bcd1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.bcd2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.bcd3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.bcd4 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) bus.blank_lz = ~bus.blank_lz;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    bus.done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Downstream consumer of the double_dabble binary-to-BCD converter. Captures the five BCD digits when a conversion completes and time-multiplexes them onto an 8-anode, active-low common-anode seven-segment display. Provides leading-zero blanking, inter-digit ghosting blank time and a dash glyph for invalid BCD. Sits between double_dabble and the board display pins.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz clk -> 1 kHz per digit); legal range >= 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
done  input  1  one-cycle strobe from double_dabble; bcd0..bcd4 are valid in this cycle.
bcd0  input  4  ones digit.
bcd1  input  4  tens digit.
bcd2  input  4  hundreds digit.
bcd3  input  4  thousands digit.
bcd4  input  4  ten-thousands digit.
blank_lz  input  1  1 = leading-zero blanking enabled; sampled every cycle.
an  output  8  anode enables, active-low; an[i] selects digit i.
seg  output  7  cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a.
dp  output  1  decimal point, active-low; tied to 1 (off).

Behaviour:
- Reset: digit registers d0..d4 = 0; slot counter cnt = 0; index idx = 0; an = 8'hFF; seg = 7'h7F; dp = 1.
- Capture: if done = 1 at edge k, d0..d4 take bcd0..bcd4 at edge k. bcd inputs are ignored whenever done = 0.
- Slot counter: cnt counts 0..REFRESH_DIV-1. On cnt == REFRESH_DIV-1, cnt wraps to 0 and idx advances 0->1->2->3->4->0. Frame length = 5*REFRESH_DIV cycles.
- Output register: an and seg are registered and reflect cnt, idx and d* as they stood before the edge, giving one cycle of latency.
- Blank window: when cnt < BLANK_CYCLES, an = 8'hFF and seg = 7'h7F.
- Lit window: otherwise an = ~(1 << idx) and seg = decode(d[idx]).
- Digit blanking: if the selected digit is blanked, an = 8'hFF and seg = 7'h7F for the whole slot.
- an[7:5] are always 1.
- Leading-zero rule (blank_lz = 1): digit i (i >= 1) is blanked iff d[i] through d4 are all 0. Digit 0 is never blanked. With blank_lz = 0, no digit is blanked.
- Decode: 0..9 map to standard glyphs: 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10. Values 10..15 map to dash 7'h3F.
- A non-zero value of 10..15 counts as non-zero for the leading-zero rule.
- Simultaneous events:
  - reset and done in the same cycle: reset wins and nothing is captured.
  - done mid-slot: the new value shows from the next cycle; the scan phase is not disturbed.
- Reset mid-scan: an = 8'hFF at the next edge; scanning restarts at idx 0 with cnt = 0.

Decomposition:
- Package seven_seg_pkg holds:
  - NUM_DIGITS = 5
  - glyph constants SEG_0..SEG_9, SEG_DASH = 7'h3F, SEG_OFF = 7'h7F
  - AN_OFF = 8'hFF
- Sub-module bcd_to_seg: purely combinational 4-bit BCD to 7-bit active-low decoder, one instance on the muxed digit. It is reused elsewhere in the display path.

Test Plan:
All scenarios use REFRESH_DIV = 8 and BLANK_CYCLES = 2, giving a 40-cycle frame.
1. Reset: hold reset 3 cycles -> an = 8'hFF, seg = 7'h7F, dp = 1. Release -> first lit slot, digit 0 showing 7'h40, starts at cycle 3 after release.
2. Load 754: pulse done with bcd4..bcd0 = 0,0,7,5,4 and blank_lz = 1. Over one frame:
   - an = 8'hFE with seg 7'h19, an = 8'hFD with 7'h12, an = 8'hFB with 7'h78, each for 6 cycles.
   - slots 3 and 4 keep an = 8'hFF.
3. Same data with blank_lz = 0 -> slots 3 and 4 show an = 8'hF7 and 8'hEF with seg 7'h40.
4. Load 00000 with blank_lz = 1 -> only digit 0 lights (an = 8'hFE, seg 7'h40). Load 10000 -> all five digits light, digits 0..3 showing 7'h40.
5. Hold and dash:
   - Change bcd inputs with done = 0 -> display unchanged for 2 full frames.
   - Pulse done with bcd1 = 4'd12 -> slot 1 shows 7'h3F, and digit 1 is not leading-zero blanked.
6. Conflicts:
   - Assert reset mid-slot 2 together with done -> an = 8'hFF next edge; digits remain 0; scan restarts at idx 0.
   - Every frame: verify the blank window gives an = 8'hFF for exactly 2 cycles at each slot boundary.
